inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
Instruction-fetch stage directly downstream of the PC register. Takes the current fetch PC and chip-enable, and issues one request at a time on a split address/data instruction-SRAM-like bus. Drives the inst_stall bit (stall[0]) that holds the PC until the fetch completes, and registers the returned instruction and its PC into the IF/ID output for the decode stage. Supports a flush that drops the in-flight fetch and invalidates IF/ID.

Parameters:
ADDR_W, 32, width of instruction address and PC.
DATA_W, 32, width of instruction word.
NOP_INST, 32'h0000_0000, instruction word driven when IF/ID is invalid.

Ports:
clk  in  1  clock.
rst  in  1  reset, synchronous, active-high.
pc_i  in  ADDR_W  fetch address from the PC register.
ce_i  in  1  fetch enable from the PC register; 0 means no fetch.
later_stall_i  in  3  {data_stall, exe_stall, id_stall} from the downstream stages.
flush_i  in  1  discard the in-flight fetch and invalidate IF/ID.
inst_req  out  1  request valid to the instruction memory.
inst_addr  out  ADDR_W  request address; equals pc_i while inst_req=1.
inst_addr_ok  in  1  memory accepted the address this cycle.
inst_data_ok  in  1  read data valid this cycle.
inst_rdata  in  DATA_W  read data.
inst_stall_o  out  1  stall[0] to the PC register and the pipeline stall logic.
if_pc_o  out  ADDR_W  IF/ID registered PC.
if_inst_o  out  DATA_W  IF/ID registered instruction.
if_valid_o  out  1  IF/ID contents valid.

Behaviour:
- States: IDLE, WAIT_ADDR, WAIT_DATA, HOLD. Reset: state=IDLE, discard=0, buffer cleared, if_pc_o=0, if_inst_o=NOP_INST, if_valid_o=0, inst_req=0.
- IDLE: if ce_i=1 and flush_i=0, go to WAIT_ADDR next cycle.
- WAIT_ADDR: inst_req=1 (combinational) and inst_addr=pc_i.
  - inst_addr_ok=1 -> WAIT_DATA.
  - flush_i=1 with addr_ok=0 -> IDLE, request withdrawn.
  - flush_i=1 with addr_ok=1 -> WAIT_DATA with discard=1.
- WAIT_DATA: inst_req=0.
  - inst_data_ok=1, discard=0, flush_i=0: the fetch completes. If later_stall_i==0, capture into IF/ID and go to IDLE. Otherwise store rdata and pc in the buffer and go to HOLD.
  - inst_data_ok=1 with discard=1 or flush_i=1: drop the data, clear discard, go to IDLE.
  - flush_i=1 without data_ok: set discard=1 and stay in WAIT_DATA.
- HOLD: the instruction is buffered.
  - When later_stall_i==0, capture the buffer into IF/ID and go to IDLE.
  - flush_i=1: drop the buffer and go to IDLE.
- inst_stall_o = ce_i and not complete.
  - complete = (WAIT_DATA and data_ok and !discard and !flush_i) or (HOLD and !flush_i).
  - This is combinational, so the PC advances in the same cycle the instruction is captured. PC and IF/ID update on the same edge only when the full stall vector is 0.
- IF/ID update at each clock edge, in priority order:
  - rst -> reset values.
  - flush_i -> if_valid_o=0, if_inst_o=NOP_INST.
  - capture -> load pc/inst, if_valid_o=1.
  - any later_stall_i bit set -> hold.
  - otherwise, with no capture -> bubble (if_valid_o=0, if_inst_o=NOP_INST).
- Throughput: at most one outstanding request. Best case is 3 cycles per instruction (IDLE→WAIT_ADDR→WAIT_DATA). The memory must return data_ok no earlier than the cycle after addr_ok.
- ce_i=0: no request is issued and inst_stall_o=0. A fetch already in flight still completes or drops normally.
- Reset mid-transaction returns to IDLE. Any later data_ok is ignored, because it only matters in WAIT_DATA.

Decomposition:
- The shared defines header gains the state encodings, NOP_INST, and the bit indices of the stall vector (INST_STALL=0, ID_STALL=1, EXE_STALL=2, DATA_STALL=3).
- One natural sub-module is if_id_reg, which holds the IF/ID output register with its flush, bubble and hold priority. The FSM and skid buffer stay in inst_fetch.

Test Plan:
- Reset release with ce_i=1, pc_i=32'hbfc0_0000, addr_ok at cycle 1, data_ok with rdata=32'h2408_0001 at cycle 2 -> inst_req=1 only in the WAIT_ADDR cycle. inst_stall_o=0 only in the data_ok cycle. The next edge gives if_pc_o=bfc0_0000, if_inst_o=2408_0001, if_valid_o=1.
- addr_ok held low for 3 cycles -> inst_req and inst_addr stay stable, inst_stall_o=1 throughout, IF/ID shows a bubble (valid=0).
- data_ok arrives while later_stall_i=3'b001 for 2 cycles -> enter HOLD with inst_stall_o=0. IF/ID keeps its previous value. The buffered word is captured on the edge where later_stall_i becomes 0.
- flush_i in WAIT_DATA, then data_ok 2 cycles later with rdata=32'hdead_beef -> data is dropped, if_valid_o=0, FSM reaches IDLE, and the next fetch uses the new pc_i.
- flush_i in WAIT_ADDR without addr_ok -> inst_req deasserts the next cycle and no data is expected.
- rst asserted in WAIT_DATA, then a stray data_ok -> all outputs stay at reset values and IF/ID stays invalid.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared fetch-stage encodings: FSM states, NOP word and stall-vector bit positions.
// Pure constants and one helper function; there is no logic and no latency.
package inst_fetch_pkg;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WAIT_ADDR = 2'd1;
    localparam logic [1:0] S_WAIT_DATA = 2'd2;
    localparam logic [1:0] S_HOLD      = 2'd3;

    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;

    // Full pipeline stall vector; the fetch stage owns bit 0 and sees the rest.
    localparam int INST_STALL = 0;
    localparam int ID_STALL   = 1;
    localparam int EXE_STALL  = 2;
    localparam int DATA_STALL = 3;
    localparam int STALL_W    = 4;

    function automatic logic later_busy(input logic [STALL_W-2:0] later_stall);
        return |later_stall;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: reset > flush > capture > hold on later stall > bubble.
// One-cycle register; downstream stalls hold the contents, nothing is ever dropped here.
module if_id_reg
    import inst_fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_INST = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_i,
    input  logic                 capture_i,
    input  logic [STALL_W-2:0]   later_stall_i,
    input  logic [ADDR_W-1:0]    cap_pc_i,
    input  logic [DATA_W-1:0]    cap_inst_i,
    output logic [ADDR_W-1:0]    if_pc_o,
    output logic [DATA_W-1:0]    if_inst_o,
    output logic                 if_valid_o
);

    logic [ADDR_W-1:0] pc_q,    pc_d;
    logic [DATA_W-1:0] inst_q,  inst_d;
    logic              valid_q, valid_d;

    always_comb begin
        pc_d    = pc_q;
        inst_d  = inst_q;
        valid_d = valid_q;
        if (flush_i) begin
            inst_d  = NOP_INST;
            valid_d = 1'b0;
        end else if (capture_i) begin
            pc_d    = cap_pc_i;
            inst_d  = cap_inst_i;
            valid_d = 1'b1;
        end else if (!later_busy(later_stall_i)) begin
            // Decode moves on with nothing new to hand it: insert a bubble, keep the PC.
            inst_d  = NOP_INST;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= '0;
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
        end
    end

    assign if_pc_o    = pc_q;
    assign if_inst_o  = inst_q;
    assign if_valid_o = valid_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: single-outstanding request on a split addr/data bus, skid buffer, IF/ID.
// Best case 3 cycles per instruction; later-stage stalls park the returned word in HOLD.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(NOP_INST_DEF)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_W-1:0]    pc_i,
    input  logic                 ce_i,
    input  logic [STALL_W-2:0]   later_stall_i,
    input  logic                 flush_i,
    output logic                 inst_req,
    output logic [ADDR_W-1:0]    inst_addr,
    input  logic                 inst_addr_ok,
    input  logic                 inst_data_ok,
    input  logic [DATA_W-1:0]    inst_rdata,
    output logic                 inst_stall_o,
    output logic [ADDR_W-1:0]    if_pc_o,
    output logic [DATA_W-1:0]    if_inst_o,
    output logic                 if_valid_o
);

    logic [1:0]        state_q,    state_d;
    logic              discard_q,  discard_d;
    logic [ADDR_W-1:0] req_pc_q,   req_pc_d;
    logic [ADDR_W-1:0] buf_pc_q,   buf_pc_d;
    logic [DATA_W-1:0] buf_inst_q, buf_inst_d;

    logic              capture;
    logic [ADDR_W-1:0] cap_pc;
    logic [DATA_W-1:0] cap_inst;
    logic              complete;
    logic              addr_acc;
    logic              busy;

    assign busy      = later_busy(later_stall_i);
    assign inst_req  = (state_q == S_WAIT_ADDR) && ce_i;
    assign inst_addr = pc_i;
    assign addr_acc  = inst_req && inst_addr_ok;

    // Combinational so the PC register advances on the same edge that IF/ID captures.
    assign complete  = ((state_q == S_WAIT_DATA) && inst_data_ok && !discard_q && !flush_i)
                    || ((state_q == S_HOLD) && !flush_i);
    assign inst_stall_o = ce_i && !complete;

    always_comb begin
        state_d    = state_q;
        discard_d  = discard_q;
        req_pc_d   = req_pc_q;
        buf_pc_d   = buf_pc_q;
        buf_inst_d = buf_inst_q;
        capture    = 1'b0;
        cap_pc     = buf_pc_q;
        cap_inst   = buf_inst_q;
        case (state_q)
            S_IDLE: begin
                if (ce_i && !flush_i) begin
                    state_d = S_WAIT_ADDR;
                end
            end
            S_WAIT_ADDR: begin
                if (addr_acc) begin
                    // Once the address is taken the data beat must still be absorbed.
                    state_d   = S_WAIT_DATA;
                    discard_d = flush_i;
                    req_pc_d  = pc_i;
                end else if (flush_i || !ce_i) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT_DATA: begin
                if (inst_data_ok) begin
                    state_d   = S_IDLE;
                    discard_d = 1'b0;
                    if (!discard_q && !flush_i) begin
                        if (!busy) begin
                            capture  = 1'b1;
                            cap_pc   = req_pc_q;
                            cap_inst = inst_rdata;
                        end else begin
                            state_d    = S_HOLD;
                            buf_pc_d   = req_pc_q;
                            buf_inst_d = inst_rdata;
                        end
                    end
                end else if (flush_i) begin
                    discard_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else if (!busy) begin
                    capture = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            discard_q  <= 1'b0;
            req_pc_q   <= '0;
            buf_pc_q   <= '0;
            buf_inst_q <= NOP_INST;
        end else begin
            state_q    <= state_d;
            discard_q  <= discard_d;
            req_pc_q   <= req_pc_d;
            buf_pc_q   <= buf_pc_d;
            buf_inst_q <= buf_inst_d;
        end
    end

    if_id_reg #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .NOP_INST (NOP_INST)
    ) u_if_id (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush_i),
        .capture_i     (capture),
        .later_stall_i (later_stall_i),
        .cap_pc_i      (cap_pc),
        .cap_inst_i    (cap_inst),
        .if_pc_o       (if_pc_o),
        .if_inst_o     (if_inst_o),
        .if_valid_o    (if_valid_o)
    );

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: inputs change 1 time unit after the rising edge,
// combinational outputs are checked 1 unit later, registered outputs after the next edge.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic        ce_i;
    logic [2:0]  later_stall_i;
    logic        flush_i;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        inst_stall_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;
    logic        if_valid_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    inst_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .pc_i          (pc_i),
        .ce_i          (ce_i),
        .later_stall_i (later_stall_i),
        .flush_i       (flush_i),
        .inst_req      (inst_req),
        .inst_addr     (inst_addr),
        .inst_addr_ok  (inst_addr_ok),
        .inst_data_ok  (inst_data_ok),
        .inst_rdata    (inst_rdata),
        .inst_stall_o  (inst_stall_o),
        .if_pc_o       (if_pc_o),
        .if_inst_o     (if_inst_o),
        .if_valid_o    (if_valid_o)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; ce_i = 1'b1; pc_i = 32'hbfc0_0000; later_stall_i = 3'b000; flush_i = 1'b0;
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0;
        tick(); tick();
        settle();
        checks++; if (inst_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%0h exp=0", inst_req); end
        checks++; if (inst_stall_o !== 1'b1) begin failures++; $display("FAIL reset_stall got=%0h exp=1", inst_stall_o); end
        checks++; if (if_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", if_valid_o); end
        checks++; if (if_inst_o !== 32'h0) begin failures++; $display("FAIL reset_inst got=%08h exp=00000000", if_inst_o); end
        checks++; if (if_pc_o !== 32'h0) begin failures++; $display("FAIL reset_pc got=%08h exp=00000000", if_pc_o); end
    endtask

    task automatic test_basic;
        rst = 1'b0;
        settle();
        checks++; if (inst_req !== 1'b0) begin failures++; $display("FAIL basic_c0_req got=%0h exp=0", inst_req); end
        checks++; if (inst_stall_o !== 1'b1) begin failures++; $display("FAIL basic_c0_stall got=%0h exp=1", inst_stall_o); end
        tick();
        inst_addr_ok = 1'b1;
        settle();
        checks++; if (inst_req !== 1'b1) begin failures++; $display("FAIL basic_c1_req got=%0h exp=1", inst_req); end
        checks++; if (inst_addr !== 32'hbfc0_0000) begin failures++; $display("FAIL basic_c1_addr got=%08h exp=bfc00000", inst_addr); end
        checks++; if (inst_stall_o !== 1'b1) begin failures++; $display("FAIL basic_c1_stall got=%0h exp=1", inst_stall_o); end
        tick();
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h2408_0001;
        settle();
        checks++; if (inst_req !== 1'b0) begin failures++; $display("FAIL basic_c2_req got=%0h exp=0", inst_req); end
        checks++; if (inst_stall_o !== 1'b0) begin failures++; $display("FAIL basic_c2_stall got=%0h exp=0", inst_stall_o); end
        tick();
        inst_data_ok = 1'b0;
        settle();
        checks++; if (if_pc_o !== 32'hbfc0_0000) begin failures++; $display("FAIL basic_if_pc got=%08h exp=bfc00000", if_pc_o); end
        checks++; if (if_inst_o !== 32'h2408_0001) begin failures++; $display("FAIL basic_if_inst got=%08h exp=24080001", if_inst_o); end
        checks++; if (if_valid_o !== 1'b1) begin failures++; $display("FAIL basic_if_valid got=%0h exp=1", if_valid_o); end
        checks++; if (inst_stall_o !== 1'b1 || inst_req !== 1'b0) begin failures++; $display("FAIL basic_c3_idle stall=%0h req=%0h exp stall=1 req=0", inst_stall_o, inst_req); end
    endtask

    task automatic test_hold;
        later_stall_i = 3'b001; pc_i = 32'hbfc0_0004;
        tick();
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h3c01_1234;
        settle();
        checks++; if (inst_stall_o !== 1'b0) begin failures++; $display("FAIL hold_dataok_stall got=%0h exp=0", inst_stall_o); end
        tick();
        inst_data_ok = 1'b0;
        settle();
        checks++; if (if_inst_o !== 32'h2408_0001 || if_valid_o !== 1'b1) begin failures++; $display("FAIL hold_keep1 inst=%08h valid=%0h exp 24080001/1", if_inst_o, if_valid_o); end
        checks++; if (inst_stall_o !== 1'b0 || inst_req !== 1'b0) begin failures++; $display("FAIL hold_state stall=%0h req=%0h exp 0/0", inst_stall_o, inst_req); end
        tick();
        checks++; if (if_pc_o !== 32'hbfc0_0000 || if_valid_o !== 1'b1) begin failures++; $display("FAIL hold_keep2 pc=%08h valid=%0h exp bfc00000/1", if_pc_o, if_valid_o); end
        later_stall_i = 3'b000;
        settle();
        checks++; if (inst_stall_o !== 1'b0) begin failures++; $display("FAIL hold_release_stall got=%0h exp=0", inst_stall_o); end
        tick();
        checks++; if (if_pc_o !== 32'hbfc0_0004) begin failures++; $display("FAIL hold_cap_pc got=%08h exp=bfc00004", if_pc_o); end
        checks++; if (if_inst_o !== 32'h3c01_1234) begin failures++; $display("FAIL hold_cap_inst got=%08h exp=3c011234", if_inst_o); end
        checks++; if (if_valid_o !== 1'b1) begin failures++; $display("FAIL hold_cap_valid got=%0h exp=1", if_valid_o); end
    endtask

    task automatic test_addr_wait;
        pc_i = 32'hbfc0_0008;
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hbfc0_0008) begin failures++; $display("FAIL addrwait_req[%0d] req=%0h addr=%08h exp 1/bfc00008", i, inst_req, inst_addr); end
            checks++; if (inst_stall_o !== 1'b1) begin failures++; $display("FAIL addrwait_stall[%0d] got=%0h exp=1", i, inst_stall_o); end
            checks++; if (if_valid_o !== 1'b0 || if_inst_o !== 32'h0) begin failures++; $display("FAIL addrwait_bubble[%0d] valid=%0h inst=%08h exp 0/00000000", i, if_valid_o, if_inst_o); end
            tick();
        end
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h8c02_0010;
        tick();
        inst_data_ok = 1'b0;
        checks++; if (if_pc_o !== 32'hbfc0_0008 || if_inst_o !== 32'h8c02_0010 || if_valid_o !== 1'b1) begin failures++; $display("FAIL addrwait_cap pc=%08h inst=%08h valid=%0h exp bfc00008/8c020010/1", if_pc_o, if_inst_o, if_valid_o); end
    endtask

    task automatic test_flush_wait_data;
        pc_i = 32'hbfc0_000c;
        tick();
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0; flush_i = 1'b1;
        settle();
        checks++; if (inst_stall_o !== 1'b1) begin failures++; $display("FAIL flushd_stall got=%0h exp=1", inst_stall_o); end
        tick();
        flush_i = 1'b0;
        checks++; if (if_valid_o !== 1'b0 || if_inst_o !== 32'h0) begin failures++; $display("FAIL flushd_ifid valid=%0h inst=%08h exp 0/00000000", if_valid_o, if_inst_o); end
        checks++; if (inst_req !== 1'b0 || inst_stall_o !== 1'b1) begin failures++; $display("FAIL flushd_wait req=%0h stall=%0h exp 0/1", inst_req, inst_stall_o); end
        tick();
        inst_data_ok = 1'b1; inst_rdata = 32'hdead_beef;
        settle();
        checks++; if (inst_stall_o !== 1'b1) begin failures++; $display("FAIL flushd_drop_stall got=%0h exp=1", inst_stall_o); end
        tick();
        inst_data_ok = 1'b0; pc_i = 32'hbfc0_0100;
        settle();
        checks++; if (if_valid_o !== 1'b0 || if_inst_o !== 32'h0) begin failures++; $display("FAIL flushd_dropped valid=%0h inst=%08h exp 0/00000000", if_valid_o, if_inst_o); end
        checks++; if (inst_req !== 1'b0) begin failures++; $display("FAIL flushd_idle_req got=%0h exp=0", inst_req); end
        tick();
        checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hbfc0_0100) begin failures++; $display("FAIL flushd_newpc req=%0h addr=%08h exp 1/bfc00100", inst_req, inst_addr); end
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h1234_5678;
        tick();
        inst_data_ok = 1'b0;
        checks++; if (if_pc_o !== 32'hbfc0_0100 || if_inst_o !== 32'h1234_5678 || if_valid_o !== 1'b1) begin failures++; $display("FAIL flushd_refetch pc=%08h inst=%08h valid=%0h exp bfc00100/12345678/1", if_pc_o, if_inst_o, if_valid_o); end
    endtask

    task automatic test_flush_wait_addr;
        pc_i = 32'hbfc0_0200;
        tick();
        flush_i = 1'b1;
        settle();
        checks++; if (inst_req !== 1'b1) begin failures++; $display("FAIL flusha_req_before got=%0h exp=1", inst_req); end
        tick();
        flush_i = 1'b0; ce_i = 1'b0;
        settle();
        checks++; if (inst_req !== 1'b0 || inst_stall_o !== 1'b0) begin failures++; $display("FAIL flusha_withdrawn req=%0h stall=%0h exp 0/0", inst_req, inst_stall_o); end
        inst_data_ok = 1'b1; inst_rdata = 32'h5555_aaaa;
        tick();
        inst_data_ok = 1'b0;
        checks++; if (if_valid_o !== 1'b0 || inst_req !== 1'b0) begin failures++; $display("FAIL flusha_nodata valid=%0h req=%0h exp 0/0", if_valid_o, inst_req); end
    endtask

    task automatic test_reset_mid;
        ce_i = 1'b1; pc_i = 32'hbfc0_0300;
        tick();
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0; ce_i = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'hcafe_f00d;
        tick();
        inst_data_ok = 1'b0;
        settle();
        checks++; if (if_valid_o !== 1'b0 || if_inst_o !== 32'h0 || if_pc_o !== 32'h0) begin failures++; $display("FAIL rstmid_ifid valid=%0h inst=%08h pc=%08h exp 0/00000000/00000000", if_valid_o, if_inst_o, if_pc_o); end
        checks++; if (inst_req !== 1'b0 || inst_stall_o !== 1'b0) begin failures++; $display("FAIL rstmid_out req=%0h stall=%0h exp 0/0", inst_req, inst_stall_o); end
        ce_i = 1'b1;
        settle();
        checks++; if (inst_req !== 1'b0 || inst_stall_o !== 1'b1) begin failures++; $display("FAIL rstmid_idle req=%0h stall=%0h exp 0/1", inst_req, inst_stall_o); end
        tick();
        checks++; if (inst_req !== 1'b1) begin failures++; $display("FAIL rstmid_restart req=%0h exp=1", inst_req); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_addr_wait();
        test_flush_wait_data();
        test_flush_wait_addr();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
